// File: rtl/rom_read_arbiter_if.sv
// One requester port of the ROM arbiter: a request channel and a response channel,
// each with a valid/ready handshake.
interface rom_read_arbiter_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              rsp_ready;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/rom_read_arbiter.sv
// Shares one synchronous-read instruction ROM between instruction fetch and data-side
// constant loads, with range/alignment fault checking and a fixed two-cycle response.
module rom_read_arbiter #(
    parameter int unsigned WORDS       = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter bit          ROUND_ROBIN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    rom_read_arbiter_if.slave if_bus,
    rom_read_arbiter_if.slave ld_bus,
    output logic [31:0]       rom_addr,
    input  logic [31:0]       rom_data,
    output logic              busy
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned EXT_W  = ADDR_W + 1;
    localparam logic [EXT_W-1:0] WINDOW_BYTES = EXT_W'(WORDS) << 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              gnt_ld_q, gnt_ld_d;
    logic              err_q, err_d;
    logic              last_ld_q, last_ld_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

    logic              sel_ld_c;
    logic              accept_c;
    logic              addr_err_c;
    logic              rsp_fire_c;
    logic [ADDR_W-1:0] req_addr_c;
    logic [EXT_W-1:0]  diff_c;

    // Grant selection and address checking; the 33-bit difference exposes underflow.
    always_comb begin
        sel_ld_c = 1'b0;
        if (ld_bus.req_valid && if_bus.req_valid) begin
            sel_ld_c = ROUND_ROBIN ? !last_ld_q : 1'b1;
        end else if (ld_bus.req_valid) begin
            sel_ld_c = 1'b1;
        end
        accept_c   = (state_q == IDLE) && !rst && (if_bus.req_valid || ld_bus.req_valid);
        req_addr_c = sel_ld_c ? ld_bus.req_addr : if_bus.req_addr;
        diff_c     = {1'b0, req_addr_c} - {1'b0, BASE_ADDR};
        addr_err_c = (req_addr_c[1:0] != 2'b00) || diff_c[ADDR_W]
                     || ({1'b0, diff_c[ADDR_W-1:0]} >= WINDOW_BYTES);
        rsp_fire_c = (state_q == RESP) && (gnt_ld_q ? ld_bus.rsp_ready : if_bus.rsp_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept_c) state_d = READ;
            READ:    state_d = RESP;
            RESP:    if (rsp_fire_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Transaction context captured at acceptance and held until the response retires.
    always_comb begin
        gnt_ld_d   = gnt_ld_q;
        err_d      = err_q;
        last_ld_d  = last_ld_q;
        rom_addr_d = rom_addr_q;
        if (accept_c) begin
            gnt_ld_d   = sel_ld_c;
            err_d      = addr_err_c;
            last_ld_d  = sel_ld_c;
            rom_addr_d = addr_err_c ? '0 : diff_c[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_ld_q   <= 1'b0;
            err_q      <= 1'b0;
            last_ld_q  <= 1'b1;
            rom_addr_q <= '0;
        end else begin
            gnt_ld_q   <= gnt_ld_d;
            err_q      <= err_d;
            last_ld_q  <= last_ld_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    // Response data passes straight from the ROM since rom_addr is held through RESP.
    always_comb begin
        if_bus.req_ready = accept_c && !sel_ld_c;
        ld_bus.req_ready = accept_c && sel_ld_c;
        if_bus.rsp_valid = 1'b0;
        if_bus.rsp_data  = '0;
        if_bus.rsp_err   = 1'b0;
        ld_bus.rsp_valid = 1'b0;
        ld_bus.rsp_data  = '0;
        ld_bus.rsp_err   = 1'b0;
        if (state_q == RESP) begin
            if (gnt_ld_q) begin
                ld_bus.rsp_valid = 1'b1;
                ld_bus.rsp_data  = err_q ? DATA_W'(0) : rom_data;
                ld_bus.rsp_err   = err_q;
            end else begin
                if_bus.rsp_valid = 1'b1;
                if_bus.rsp_data  = err_q ? DATA_W'(0) : rom_data;
                if_bus.rsp_err   = err_q;
            end
        end
        rom_addr = rom_addr_q;
        busy     = (state_q != IDLE);
    end
endmodule

// File: doc/rom_read_arbiter.md
Name: rom_read_arbiter

Overview:
- Shares the single synchronous-read instruction ROM between two requesters: instruction fetch (IF) and data-side constant loads (LD).
- Each side uses valid/ready handshakes on separate request and response channels.
- Adds address range and alignment checking, and gives a fixed response latency.
- Sits between the core's fetch/LSU and the ROM. The ROM samples a byte address on every clk edge and returns mem[addr[31:2]] one cycle later.

Parameters:
- WORDS, 4096: ROM depth in 32-bit words; the legal window is WORDS*4 bytes.
- BASE_ADDR, 32'h0000_0000: byte address of ROM word 0 in the core address map.
- ROUND_ROBIN, 1: 1 = alternate grants on contention; 0 = LD always wins.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- if_req_valid  in  1  IF request valid.
- if_req_addr  in  32  IF byte address.
- if_req_ready  out  1  IF request accepted this cycle.
- if_rsp_valid  out  1  IF response valid.
- if_rsp_data  out  32  IF instruction word.
- if_rsp_err  out  1  IF address fault.
- if_rsp_ready  in  1  IF consumer accepts the response.
- ld_req_valid  in  1  LD request valid.
- ld_req_addr  in  32  LD byte address.
- ld_req_ready  out  1  LD request accepted.
- ld_rsp_valid  out  1  LD response valid.
- ld_rsp_data  out  32  LD data word.
- ld_rsp_err  out  1  LD address fault.
- ld_rsp_ready  in  1  LD consumer accepts the response.
- rom_addr  out  32  registered byte address to the ROM (relative to BASE_ADDR).
- rom_data  in  32  ROM read data, valid one cycle after rom_addr changes.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- States:
  - IDLE: no transaction.
  - READ: ROM access in flight.
  - RESP: response presented.
- Request handshake:
  - A request transfers when valid & ready are both high at a rising edge.
  - Requesters hold valid and addr stable until accepted.
  - *_req_ready is combinational: high only in IDLE, only for the granted side.
- Arbitration in IDLE:
  - Only one valid: that side is granted.
  - Both valid, ROUND_ROBIN=1: grant the side not granted last; last_grant resets to LD, so IF wins the first tie.
  - Both valid, ROUND_ROBIN=0: LD is granted.
  - last_grant updates only on acceptance.
- On acceptance (edge E0):
  - Latch grant id and err.
  - rom_addr <= err ? 0 : addr - BASE_ADDR.
  - State -> READ.
- err is set when:
  - addr[1:0] != 0, or
  - addr < BASE_ADDR, or
  - addr - BASE_ADDR >= WORDS*4 (32-bit unsigned compare, no wrap).
- READ: unconditional -> RESP at E1. The ROM captures mem[rom_addr[31:2]] at E1.
- RESP:
  - The granted side's rsp_valid = 1.
  - rsp_data = err ? 0 : rom_data. rom_addr is held, so rom_data is stable.
  - rsp_err = err.
  - On rsp_valid & rsp_ready -> IDLE. Otherwise hold all response outputs indefinitely (backpressure).
- Latency and throughput:
  - Response visible in the cycle after E1, i.e. 2 cycles after acceptance.
  - No new request is accepted in RESP. Minimum spacing between acceptances is 3 cycles.
- Non-granted side: rsp_valid = 0, rsp_data = 0, rsp_err = 0 at all times.
- A request that arrives while busy waits; its ready stays low.
- Reset values (including reset mid-READ/RESP, where the pending response is discarded, not replayed):
  - state = IDLE, all *_rsp_valid = 0, *_rsp_data = 0, *_rsp_err = 0.
  - rom_addr = 0, last_grant = LD, busy = 0.
  - *_req_ready is low during any cycle where rst = 1.
- Simultaneous event: requester valid high on the same cycle as rst -> not accepted.

Test Plan:
- Single IF: mem[5]=32'h0050_0093, if_req_addr=32'h14 accepted at E0 -> if_rsp_valid high 2 cycles later, data 32'h0050_0093, err=0; ld_rsp_valid stays 0.
- Contention, ROUND_ROBIN=1: both valid continuously, IF=0x0, LD=0x8 -> grant order IF, LD, IF, LD; each accepted 3 cycles apart with if_rsp_ready=ld_rsp_ready=1.
- Contention, ROUND_ROBIN=0: both valid -> LD granted every time while ld_req_valid stays high; IF starves.
- Faults, BASE_ADDR=32'h1000, WORDS=4096: addr 0x1002, addr 0x0FFC, and addr 0x5000 -> rsp_err=1, data 0. Addr 0x4FFC -> err=0, data mem[4095].
- Backpressure: ld_rsp_ready low for 5 cycles in RESP -> ld_rsp_valid/data held constant and if_req_ready stays 0 throughout; the cycle after ld_rsp_ready=1, IF is accepted.
- Reset mid-op: assert rst in READ -> next cycle state IDLE, busy=0, no response ever issued; the first post-reset tie is granted to IF.
